// File: rtl/rr_mux_4_1_stage_if.sv
// Request/acknowledge bus for the four sources, plus the valid/ready output
// toward the consumer of the registered select stage.
interface rr_mux_4_1_stage_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [3:0]       ack;
    logic             out_ready;
    logic             out_valid;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;

    modport master (
        output req, d0, d1, d2, d3, out_ready,
        input  ack, out_valid, sel, out_data
    );

    modport slave (
        input  req, d0, d1, d2, d3, out_ready,
        output ack, out_valid, sel, out_data
    );
endinterface

// File: rtl/rr_mux_4_1_stage.sv
// Registered 4-channel round-robin selection stage: grants one requester per
// cycle, captures its word and select, and offers them on a valid/ready port.
module rr_mux_4_1_stage #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    rr_mux_4_1_stage_if.slave bus
);

    logic             vld_p0;
    logic [1:0]       sel_p0;
    logic [WIDTH-1:0] data_p0;
    logic [1:0]       last_grant_p0;

    logic             can_load;
    logic [2:0]       pick;
    logic             found;
    logic [1:0]       win;
    logic [WIDTH-1:0] win_data;
    logic             load;

    // Returns {found, index}; the candidate nearest after `last` wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    assign can_load = !vld_p0 || bus.out_ready;
    assign pick     = rr_pick(bus.req, last_grant_p0);
    assign found    = pick[2];
    assign win      = pick[1:0];
    assign load     = rst && can_load && found;

    // Only the winning channel is routed, so X on losing channels stays out.
    always_comb begin
        win_data = bus.d0;
        case (win)
            2'd0:    win_data = bus.d0;
            2'd1:    win_data = bus.d1;
            2'd2:    win_data = bus.d2;
            default: win_data = bus.d3;
        endcase
    end

    always_comb begin
        bus.ack = 4'b0000;
        if (load) bus.ack[win] = 1'b1;
    end

    // Stage p0: capture register, also the output holding register
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0        <= 1'b0;
            sel_p0        <= 2'd0;
            data_p0       <= '0;
            last_grant_p0 <= 2'd3;
        end else if (can_load) begin
            if (found) begin
                vld_p0        <= 1'b1;
                sel_p0        <= win;
                data_p0       <= win_data;
                last_grant_p0 <= win;
            end else begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.sel       = sel_p0;
    assign bus.out_data  = data_p0;

endmodule

// File: tb/tb_rr_mux_4_1_stage.sv
// Scoreboard bench for rr_mux_4_1_stage: directed stimulus queues expected
// {sel,data} words; a negedge monitor pops them on each output handshake.
module tb_rr_mux_4_1_stage;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [5:0] exp_q[$];

    rr_mux_4_1_stage_if #(.WIDTH(WIDTH)) bus ();

    rr_mux_4_1_stage #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [3:0] dat);
        exp_q.push_back({2'(ch), dat});
    endtask

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got sel=%0d data=%h with empty queue", bus.sel, bus.out_data);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("sb_sel", {6'd0, bus.sel}, {6'd0, e[5:4]});
                chk("sb_data", {4'd0, bus.out_data}, {4'd0, e[3:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int chs[5];
        logic [3:0] dats[5];
        chs  = '{0, 1, 2, 3, 0};
        dats = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        total = 0;
        bad   = 0;

        // Reset held two cycles with all requests up
        rst = 1'b0;
        bus.req = 4'hF;
        bus.d0 = 4'h5; bus.d1 = 4'h0; bus.d2 = 4'h0; bus.d3 = 4'h0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ack", {4'd0, bus.ack}, 8'h00);
            chk("rst_valid", {7'd0, bus.out_valid}, 8'h00);
            chk("rst_sel", {6'd0, bus.sel}, 8'h00);
            chk("rst_data", {4'd0, bus.out_data}, 8'h00);
        end
        rst = 1'b1;
        #1;
        chk("first_ack", {4'd0, bus.ack}, 8'h01);
        push(0, 4'h5);
        tick();
        bus.req = 4'h0;
        #1;
        chk("idle_ack", {4'd0, bus.ack}, 8'h00);
        tick();
        chk("drain_valid", {7'd0, bus.out_valid}, 8'h00);

        // Single request on channel 2
        bus.req = 4'b0100;
        bus.d2 = 4'hC;
        #1;
        chk("single_ack", {4'd0, bus.ack}, 8'h04);
        push(2, 4'hC);
        tick();
        bus.req = 4'h0;
        chk("single_valid", {7'd0, bus.out_valid}, 8'h01);
        chk("single_sel", {6'd0, bus.sel}, 8'h02);
        chk("single_data", {4'd0, bus.out_data}, 8'h0C);
        tick();
        chk("single_drop", {7'd0, bus.out_valid}, 8'h00);

        // Grant channel 3 so the full sweep starts from channel 0
        bus.req = 4'b1000;
        bus.d3 = 4'hD;
        #1;
        chk("pre_ack3", {4'd0, bus.ack}, 8'h08);
        push(3, 4'hD);
        tick();

        bus.d0 = 4'hA; bus.d1 = 4'hB; bus.d2 = 4'hC; bus.d3 = 4'hD;
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_ack", {4'd0, bus.ack}, 8'(1 << chs[i]));
            push(chs[i], dats[i]);
            tick();
            chk("rr_valid", {7'd0, bus.out_valid}, 8'h01);
        end

        // Backpressure while holding channel 1's word
        #1;
        chk("bp_load_ack", {4'd0, bus.ack}, 8'h02);
        push(1, 4'hB);
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ack", {4'd0, bus.ack}, 8'h00);
            chk("bp_sel", {6'd0, bus.sel}, 8'h01);
            chk("bp_data", {4'd0, bus.out_data}, 8'h0B);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_resume_ack", {4'd0, bus.ack}, 8'h04);
        push(2, 4'hC);
        tick();
        bus.req = 4'h0;
        tick();

        // Skip and wrap with unknown data on idle channels
        bus.req = 4'b1000;
        #1;
        chk("wrap_ack3", {4'd0, bus.ack}, 8'h08);
        push(3, 4'hD);
        tick();
        bus.d1 = 'x;
        bus.d2 = 'x;
        bus.req = 4'b1001;
        #1;
        chk("wrap_ack0", {4'd0, bus.ack}, 8'h01);
        push(0, 4'hA);
        tick();
        chk("wrap_known", {7'd0, ^bus.out_data === 1'bx}, 8'h00);
        chk("skip_ack3", {4'd0, bus.ack}, 8'h08);
        push(3, 4'hD);
        tick();
        chk("skip_ack0", {4'd0, bus.ack}, 8'h01);
        push(0, 4'hA);
        tick();
        bus.req = 4'h0;
        tick();

        // Reset while a word is stalled at the output
        bus.d1 = 4'h7;
        bus.req = 4'b0010;
        #1;
        chk("mid_load_ack", {4'd0, bus.ack}, 8'h02);
        tick();
        bus.out_ready = 1'b0;
        bus.req = 4'h0;
        chk("mid_hold_valid", {7'd0, bus.out_valid}, 8'h01);
        chk("mid_hold_data", {4'd0, bus.out_data}, 8'h07);
        tick();
        rst = 1'b0;
        bus.req = 4'hF;
        #1;
        chk("mid_rst_ack", {4'd0, bus.ack}, 8'h00);
        tick();
        chk("mid_rst_valid", {7'd0, bus.out_valid}, 8'h00);
        chk("mid_rst_data", {4'd0, bus.out_data}, 8'h00);
        chk("mid_rst_sel", {6'd0, bus.sel}, 8'h00);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.d0 = 4'hA;
        #1;
        chk("restart_ack", {4'd0, bus.ack}, 8'h01);
        push(0, 4'hA);
        tick();
        bus.req = 4'h0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_4_1_stage.md
Name: rr_mux_4_1_stage

Overview:
- Registered 4-channel round-robin selection stage for 4-bit data.
- Sits directly upstream of the 4:1 data multiplexer.
- Arbitrates four request/acknowledge sources and drives the registered 2-bit select plus the captured data word.
- Presents the result to the consumer through a valid/ready output handshake.

Parameters:
WIDTH, 4, data width of each channel and of out_data

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
req  input  4  per-channel request; req[i] means d{i} holds a valid word
d0  input  WIDTH  channel 0 data
d1  input  WIDTH  channel 1 data
d2  input  WIDTH  channel 2 data
d3  input  WIDTH  channel 3 data
ack  output  4  one-hot, combinational; ack[i]=1 means d{i} is captured at this edge
out_ready  input  1  consumer can accept out_data this cycle
out_valid  output  1  out_data/sel hold a valid word
sel  output  2  registered index of the channel that supplied out_data
out_data  output  WIDTH  registered captured word

Behaviour:
- Reset (rst==0 at an edge):
  - out_valid=0, out_data=0, sel=0.
  - Internal last_grant=3, so the first search starts at channel 0.
  - ack is forced to 0 while rst==0.
  - Reset mid-operation discards any held word; there is no partial transfer.
- Load enable: can_load = !out_valid || out_ready.
- Search order: last_grant+1, +2, +3, +4 (mod 4). The first index with req set wins.
- ack[i]=1 only when can_load, req[i]=1 and i is the winner. At most one ack bit is set. ack never asserts without req.
- At the edge with ack[i]=1:
  - out_data<=d{i}, sel<=i, out_valid<=1, last_grant<=i.
  - Latency from request to out_valid is 1 cycle.
- At an edge with can_load=1 and no req:
  - out_valid<=0.
  - out_data and sel hold their previous values.
  - last_grant is unchanged.
- At an edge with out_valid=1 and out_ready=0:
  - All registers hold and ack=0.
  - out_data/sel must stay stable while out_valid=1 and out_ready=0.
- Simultaneous pop and load: out_valid=1, out_ready=1 and a winner exists.
  - The old word is consumed and the new word loaded in the same edge.
  - Sustains 1 word/cycle throughput.
- Wrap-around: after last_grant=3 the search starts at 0.
  - A channel requesting continuously is granted at least once every 4 accepted transfers (no starvation).
- A requester must hold req and its data stable until it sees ack. Dropping req before ack is permitted and simply withdraws the request.
- Data of non-winning channels may be X; X must not propagate to out_data or sel.
- out_valid, sel and out_data are registers only. ack is the only combinational output, derived from req, out_valid, out_ready and last_grant.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'hF -> ack=0, out_valid=0, sel=0, out_data=0. Release rst -> first ack=4'b0001.
- Single request: req=4'b0100, d2=4'hC, out_ready=1 -> ack=4'b0100 that cycle. Next cycle out_valid=1, sel=2, out_data=4'hC. With req=0 afterwards, out_valid=0 one cycle later.
- Full round-robin: req=4'hF, d0..d3=A,B,C,D, out_ready=1 continuously -> sel sequence 0,1,2,3,0 on consecutive cycles, out_data A,B,C,D,A, out_valid held 1.
- Backpressure: out_valid=1 with sel=1/out_data=4'hB, then out_ready=0 for 3 cycles with req=4'hF -> ack=0, and sel/out_data stay 1/B. Raise out_ready -> next grant is channel 2.
- Skip and wrap: after a grant on channel 3, req=4'b1001 -> channel 0 granted, then channel 3. Also d1=d2=X with req=4'b1001 -> out_data never X.
- Reset mid-operation: out_valid=1 with out_ready=0 holding 4'h7, assert rst=0 for 1 cycle -> out_valid=0 and out_data=0 next cycle. After release, arbitration restarts at channel 0.
